// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the five-stage MIPS pipeline.
//
// Holds the program counter, addresses the instruction memory with the current
// PC, and registers the fetched word together with PC+4 into the IF/ID pipeline
// register. A hazard freeze holds everything; a taken branch from the execute
// stage redirects the PC and flushes IF/ID with a bubble.
//
// Per-edge priority: rst > branch_taken > freeze > normal advance.
//
// Optional feature: define IF_STAGE_PERF_EN to add the saturating fetch_cnt and
// stall_cnt performance counters and their ports. Without it, both counters and
// ports are absent and fetch behaviour is identical.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   freeze         hazard stall: hold PC and IF/ID
//   branch_taken   redirect request from execute stage
//   branch_target  byte address of the redirect target (bits [1:0] ignored)
//   imem_addr      instruction memory word index, pc[AW+1:2]
//   imem_rdata     instruction word read combinationally at imem_addr
//   pc             current PC register
//   if_id_pc       PC+4 of the instruction held in IF/ID
//   if_id_inst     instruction held in IF/ID
//   if_id_valid    IF/ID holds a real instruction
//   fetch_cnt      instructions delivered into IF/ID (IF_STAGE_PERF_EN only)
//   stall_cnt      frozen cycles (IF_STAGE_PERF_EN only)
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   pc,
  output logic [31:0]   if_id_pc,
  output logic [31:0]   if_id_inst,
  output logic          if_id_valid
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0]   fetch_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  // What the stage does on the coming edge, already resolved by priority.
  typedef enum logic [1:0] {
    ACT_RESET,
    ACT_BRANCH,
    ACT_HOLD,
    ACT_ADVANCE
  } action_e;

  action_e     act;
  logic [31:0] pc_plus4;

  // NOTE: assign the default first so every path through always_comb writes
  // act; a missing assignment on some path would infer a latch.
  always_comb begin
    act = ACT_ADVANCE;
    if (rst)               act = ACT_RESET;
    else if (branch_taken) act = ACT_BRANCH;
    else if (freeze)       act = ACT_HOLD;
  end

  // 32-bit modulo add: 32'hFFFF_FFFC wraps to 0.
  assign pc_plus4  = pc + 32'd4;

  // Truncation of the word index makes addresses beyond the memory alias.
  assign imem_addr = pc[AW+1:2];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET: begin
        pc          <= RESET_PC;
        if_id_pc    <= 32'd0;
        if_id_inst  <= NOP_INST;
        if_id_valid <= 1'b0;
      end
      ACT_BRANCH: begin
        // The word fetched at the old PC this cycle is dropped; a bubble enters.
        pc          <= branch_target & ~32'd3;
        if_id_pc    <= 32'd0;
        if_id_inst  <= NOP_INST;
        if_id_valid <= 1'b0;
      end
      ACT_HOLD: begin
        // Freeze: every register keeps its value, so imem_addr stays put.
      end
      default: begin
        pc          <= pc_plus4;
        if_id_pc    <= pc_plus4;
        if_id_inst  <= imem_rdata;
        if_id_valid <= 1'b1;
      end
    endcase
  end

`ifdef IF_STAGE_PERF_EN
  // Counters saturate instead of wrapping so a long run never reads as small.
  always_ff @(posedge clk) begin
    if (act == ACT_RESET) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (act == ACT_ADVANCE && fetch_cnt != 32'hFFFF_FFFF)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (act == ACT_HOLD && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// The bench owns the instruction memory and a behavioural model of the fetch
// stage expressed as "what the pipeline register should contain" after each
// edge. Directed steps follow the fetch scenarios (reset, free run, freeze,
// redirect, redirect under freeze, PC wrap, reset during freeze), followed by
// a randomized run. Define IF_STAGE_PERF_EN for both RTL and bench to also
// check the counters.
// -----------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          IMEM_DEPTH = 1024;
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam int          AW         = $clog2(IMEM_DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze;
  logic          branch_taken;
  logic [31:0]   branch_target;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   pc;
  logic [31:0]   if_id_pc;
  logic [31:0]   if_id_inst;
  logic          if_id_valid;
`ifdef IF_STAGE_PERF_EN
  logic [31:0]   fetch_cnt;
  logic [31:0]   stall_cnt;
`endif

  logic [31:0] mem [IMEM_DEPTH];

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: the architectural view after the most recent edge.
  logic [31:0] m_pc;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_inst;
  logic        m_if_valid;
  longint      m_fetches;
  longint      m_stalls;

  if_stage #(
    .RESET_PC  (RESET_PC),
    .IMEM_DEPTH(IMEM_DEPTH),
    .NOP_INST  (NOP_INST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .if_id_pc     (if_id_pc),
    .if_id_inst   (if_id_inst),
    .if_id_valid  (if_id_valid)
`ifdef IF_STAGE_PERF_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Combinational instruction memory.
  assign imem_rdata = mem[imem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word index the memory sees for a given byte address (wraps with depth).
  function automatic int word_of(input logic [31:0] byte_addr);
    return int'((byte_addr / 4) % IMEM_DEPTH);
  endfunction

  // Apply one edge worth of the fetch rules to the model.
  task automatic model_edge(input logic r, input logic f, input logic b, input logic [31:0] t);
    if (r) begin
      m_pc = RESET_PC; m_if_pc = 0; m_if_inst = NOP_INST; m_if_valid = 0;
      m_fetches = 0; m_stalls = 0;
    end else if (b) begin
      m_pc = (t / 4) * 4;            // target aligned down to a word
      m_if_pc = 0; m_if_inst = NOP_INST; m_if_valid = 0;
    end else if (f) begin
      m_stalls++;
    end else begin
      m_if_inst  = mem[word_of(m_pc)];
      m_pc       = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
      m_if_pc    = m_pc;
      m_if_valid = 1;
      m_fetches++;
    end
  endtask

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(v);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".pc"},          pc,                m_pc);
    check({tag, ".imem_addr"},   32'(imem_addr),    32'(word_of(m_pc)));
    check({tag, ".if_id_pc"},    if_id_pc,          m_if_pc);
    check({tag, ".if_id_inst"},  if_id_inst,        m_if_inst);
    check({tag, ".if_id_valid"}, 32'(if_id_valid),  32'(m_if_valid));
`ifdef IF_STAGE_PERF_EN
    check({tag, ".fetch_cnt"},   fetch_cnt,         sat32(m_fetches));
    check({tag, ".stall_cnt"},   stall_cnt,         sat32(m_stalls));
`endif
  endtask

  // Drive inputs, take one edge, update the model, sample 1 time unit later.
  task automatic step(input string tag, input logic r, input logic f,
                      input logic b, input logic [31:0] t);
    rst = r; freeze = f; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_edge(r, f, b, t);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    m_pc = 32'hx; m_if_pc = 32'hx; m_if_inst = 32'hx; m_if_valid = 1'bx;
    m_fetches = 0; m_stalls = 0;
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = 32'h1000_0000 + 32'(i);
    @(negedge clk);

    // Reset, with freeze and branch also asserted to confirm reset wins.
    step("reset", 1, 1, 1, 32'h0000_0100);
    check("reset.valid0", 32'(if_id_valid), 32'd0);
    check("reset.pc0", pc, RESET_PC);

    // Two free-running cycles.
    step("run1", 0, 0, 0, 0);
    check("run1.inst", if_id_inst, 32'h1000_0000);
    check("run1.ifpc", if_id_pc, 32'd4);
    step("run2", 0, 0, 0, 0);
    check("run2.pc", pc, 32'd8);

    // Freeze three cycles at pc=8; IF/ID holds word 1.
    for (int i = 0; i < 3; i++) begin
      step("freeze", 0, 1, 0, 0);
      check("freeze.pc", pc, 32'd8);
      check("freeze.inst", if_id_inst, 32'h1000_0001);
    end
    step("resume", 0, 0, 0, 0);
    check("resume.inst", if_id_inst, 32'h1000_0002);
    step("run3", 0, 0, 0, 0);
    check("run3.pc", pc, 32'd16);

    // Branch to 0x42 -> pc 0x40, bubble, then word 16 with if_id_pc 0x44.
    step("br", 0, 0, 1, 32'h0000_0042);
    check("br.pc", pc, 32'h40);
    check("br.valid", 32'(if_id_valid), 32'd0);
    check("br.inst", if_id_inst, NOP_INST);
    step("br_next", 0, 0, 0, 0);
    check("br_next.inst", if_id_inst, 32'h1000_0010);
    check("br_next.ifpc", if_id_pc, 32'h44);

    // Branch together with freeze: redirect and flush still happen.
    step("brfz", 0, 1, 1, 32'h0000_0203);
    check("brfz.pc", pc, 32'h200);
    check("brfz.valid", 32'(if_id_valid), 32'd0);
    step("brfz_next", 0, 0, 0, 0);

    // PC wrap: jump to the last word of the address space and advance.
    step("wrap_br", 0, 0, 1, 32'hFFFF_FFFF);
    check("wrap.addr", 32'(imem_addr), 32'(IMEM_DEPTH - 1));
    step("wrap_adv", 0, 0, 0, 0);
    check("wrap.pc", pc, 32'd0);
    check("wrap.ifpc", if_id_pc, 32'd0);
    check("wrap.inst", if_id_inst, 32'h1000_0000 + 32'(IMEM_DEPTH - 1));

    // Reset, seven fetches, freeze, then reset during freeze.
    step("rst2", 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step("seven", 0, 0, 0, 0);
`ifdef IF_STAGE_PERF_EN
    check("seven.fetch_cnt", fetch_cnt, 32'd7);
`endif
    step("pre_rst_fz", 0, 1, 0, 0);
    step("rst_in_fz", 1, 1, 0, 0);
    check("rst_in_fz.valid", 32'(if_id_valid), 32'd0);
    step("post_rst1", 0, 0, 0, 0);
    check("post_rst1.inst", if_id_inst, 32'h1000_0000 + 32'(word_of(RESET_PC)));

    // Randomized run on random memory contents.
    for (int i = 0; i < IMEM_DEPTH; i++) mem[i] = $urandom;
    for (int i = 0; i < 400; i++) begin
      int r;
      logic rr, ff, bb;
      r  = $urandom_range(0, 99);
      rr = (r < 2);
      bb = (r >= 2 && r < 12);
      ff = ($urandom_range(0, 3) == 0);
      step("rand", rr, ff, bb, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
